// File: rtl/rv16_mul_pkg.sv
// Shared constants for the rv16 multiply issue sequencer: FSM encoding, default tag width
// and request-queue entry width ({tag, op_a, op_b}).
package rv16_mul_pkg;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam int TAG_W_DEF = 4;

   function automatic int entry_w(input int tag_w);
      return tag_w + 64;
   endfunction

   localparam int ENTRY_W = entry_w(TAG_W_DEF);

endpackage

// File: rtl/rv16_mul_issue_if.sv
// Decode request, multiplier and writeback signals of rv16_mul_issue.
// slave is the sequencer's view, master is the surrounding pipeline's view.
interface rv16_mul_issue_if import rv16_mul_pkg::*; #(
   parameter int TAG_W = TAG_W_DEF
);
   logic             req_valid;
   logic             req_ready;
   logic [TAG_W-1:0] req_tag;
   logic [31:0]      req_op_a;
   logic [31:0]      req_op_b;
   logic             mul_start;
   logic [31:0]      mul_op_a;
   logic [31:0]      mul_op_b;
   logic [31:0]      mul_result;
   logic             mul_done;
   logic             mul_busy;
   logic             wb_valid;
   logic             wb_ready;
   logic [TAG_W-1:0] wb_tag;
   logic [31:0]      wb_data;
   logic             busy;

   modport slave (
      input  req_valid, req_tag, req_op_a, req_op_b,
      input  mul_result, mul_done, mul_busy, wb_ready,
      output req_ready, mul_start, mul_op_a, mul_op_b,
      output wb_valid, wb_tag, wb_data, busy
   );

   modport master (
      output req_valid, req_tag, req_op_a, req_op_b,
      output mul_result, mul_done, mul_busy, wb_ready,
      input  req_ready, mul_start, mul_op_a, mul_op_b,
      input  wb_valid, wb_tag, wb_data, busy
   );

endinterface

// File: rtl/rv16_mul_req_fifo.sv
// In-order request queue for rv16_mul_issue: DEPTH entries (power of 2), synchronous
// push/pop/flush, asynchronous active-high reset of the pointers.
module rv16_mul_req_fifo import rv16_mul_pkg::*; #(
   parameter int DEPTH = 2,
   parameter int W     = ENTRY_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rv16_mul_issue.sv
// Issue/writeback sequencer around the rv16 multiplier: queues requests, keeps one multiply
// outstanding, returns tagged products. Optional RV16_MUL_ZERO_SKIP_EN bypasses zero operands.
module rv16_mul_issue import rv16_mul_pkg::*; #(
   parameter int DEPTH = 2,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   rv16_mul_issue_if.slave     bus
);
   localparam int EW = entry_w(TAG_W);

   logic [EW-1:0]    head;
   logic             q_full;
   logic             q_empty;
   logic             push;
   logic             pop;
   logic [TAG_W-1:0] head_tag;
   logic [31:0]      head_a;
   logic [31:0]      head_b;
   logic             head_zero;

   logic [0:0]       state;
   logic             drop;
   logic             start_r;
   logic [31:0]      op_a_r;
   logic [31:0]      op_b_r;
   logic [TAG_W-1:0] pend_tag;
   logic             wb_vld;
   logic [TAG_W-1:0] wb_tag_r;
   logic [31:0]      wb_data_r;

   logic             wb_free;
   logic             idle_go;
   logic             issue;
   logic             zskip;
   logic             res_done;
   logic             res_land;
   logic [31:0]      res_data;
   logic [TAG_W-1:0] res_tag;

   assign push = bus.req_valid && !q_full;

   rv16_mul_req_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata ({bus.req_tag, bus.req_op_a, bus.req_op_b}),
      .rdata (head),
      .full  (q_full),
      .empty (q_empty)
   );

   assign head_tag = head[EW-1 -: TAG_W];
   assign head_a   = head[63:32];
   assign head_b   = head[31:0];

`ifdef RV16_MUL_ZERO_SKIP_EN
   assign head_zero = (head_a == '0) || (head_b == '0);
`else
   assign head_zero = 1'b0;
`endif

   // A new result may only be launched when the writeback slot is empty or draining now.
   assign wb_free  = !wb_vld || bus.wb_ready;
   assign idle_go  = (state == S_IDLE) && !q_empty && wb_free && !flush;
   assign issue    = idle_go && !head_zero && !bus.mul_busy;
   assign zskip    = idle_go && head_zero;
   assign pop      = issue || zskip;

   assign res_done = (state == S_WAIT) && bus.mul_done && !drop && !flush;
   assign res_land = res_done || zskip;
   assign res_data = zskip ? 32'd0 : bus.mul_result;
   assign res_tag  = zskip ? head_tag : pend_tag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         drop      <= 1'b0;
         start_r   <= 1'b0;
         op_a_r    <= '0;
         op_b_r    <= '0;
         pend_tag  <= '0;
         wb_vld    <= 1'b0;
         wb_tag_r  <= '0;
         wb_data_r <= '0;
      end else begin
         start_r <= issue;

         if (state == S_IDLE) begin
            if (issue) begin
               state    <= S_WAIT;
               op_a_r   <= head_a;
               op_b_r   <= head_b;
               pend_tag <= head_tag;
            end
         end else begin
            // The multiplier cannot be aborted, so a flush only marks its result for discard.
            if (bus.mul_done) begin
               state <= S_IDLE;
               drop  <= 1'b0;
            end else if (flush) begin
               drop  <= 1'b1;
            end
         end

         if (flush) begin
            wb_vld <= 1'b0;
         end else if (res_land) begin
            wb_vld    <= 1'b1;
            wb_tag_r  <= res_tag;
            wb_data_r <= res_data;
         end else if (wb_vld && bus.wb_ready) begin
            wb_vld <= 1'b0;
         end
      end
   end

   assign bus.req_ready = !q_full;
   assign bus.mul_start = start_r;
   assign bus.mul_op_a  = op_a_r;
   assign bus.mul_op_b  = op_b_r;
   assign bus.wb_valid  = wb_vld;
   assign bus.wb_tag    = wb_tag_r;
   assign bus.wb_data   = wb_data_r;
   assign bus.busy      = !q_empty || (state != S_IDLE) || wb_vld;

endmodule
